// File: rtl/spreading_factors_pkg.sv
// Shared spreading-factor types plus the DCSK demodulator state encoding and chip-count helper.
package spreading_factors_pkg;

  typedef enum logic [1:0] {SF4 = 2'd0, SF8 = 2'd1, SF16 = 2'd2, SF32 = 2'd3} sf_t;

  localparam int MAX_SF_CHIPS = 32;
  localparam int SF_CNT_W     = $clog2(MAX_SF_CHIPS);

  typedef enum logic [1:0] {IDLE, REF, DATA, OUT} dcsk_demod_state_t;

  // Chips per symbol half: 4 << sf.
  function automatic logic [SF_CNT_W:0] sf_chips(input sf_t sf);
    return (SF_CNT_W+1)'(4) << sf;
  endfunction

endpackage

// File: rtl/dcsk_ref_buffer.sv
// Reference-half chip store: synchronous write, combinational read, shared address.
module dcsk_ref_buffer #(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              addr,
  input  logic signed [SAMPLE_W-1:0] wdata,
  output logic signed [SAMPLE_W-1:0] rdata
);

  // Contents are don't-care until written, so no reset.
  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/dcsk_demodulator.sv
// Serial DCSK demodulator: buffers the reference half, correlates the data half, emits one bit per symbol.
// Optional macro DCSK_DEMOD_CORR_OUT_EN adds the corr_o correlation output.
module dcsk_demodulator
  import spreading_factors_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 2*SAMPLE_W+5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  sf_t                        sf_i,
  input  logic signed [SAMPLE_W-1:0] chip_i,
  input  logic                       chip_valid_i,
  output logic                       chip_ready_o,
  output logic                       bit_o,
  output logic                       bit_valid_o,
  input  logic                       bit_ready_i,
  output logic                       busy_o
`ifdef DCSK_DEMOD_CORR_OUT_EN
  ,
  output logic signed [ACC_W-1:0]    corr_o
`endif
);

  localparam int PROD_W = 2*SAMPLE_W;

  dcsk_demod_state_t          state, state_nxt;
  sf_t                        sf_q, sf_nxt;
  logic [SF_CNT_W-1:0]        cnt, cnt_nxt, last_idx;
  logic signed [ACC_W-1:0]    acc, acc_nxt;
  logic signed [SAMPLE_W-1:0] ref_rd;
  logic signed [PROD_W-1:0]   prod;
  logic                       ref_we;

  assign last_idx = SF_CNT_W'(sf_chips(sf_q) - (SF_CNT_W+1)'(1));
  assign prod     = PROD_W'(chip_i) * PROD_W'(ref_rd);

  // cnt addresses both the reference write (REF) and the matching read (DATA).
  dcsk_ref_buffer #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (MAX_SF_CHIPS)
  ) u_ref_buf (
    .clk   (clk),
    .we    (ref_we),
    .addr  (cnt),
    .wdata (chip_i),
    .rdata (ref_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      sf_q  <= SF4;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      sf_q  <= sf_nxt;
    end
  end

  // chip_ready_o is 1 in every state but OUT, so chip_valid_i alone marks a transfer there.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    sf_nxt       = sf_q;
    ref_we       = 1'b0;
    chip_ready_o = 1'b1;
    bit_valid_o  = 1'b0;
    bit_o        = 1'b0;
    busy_o       = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (chip_valid_i) begin
          sf_nxt    = sf_i;
          ref_we    = 1'b1;
          cnt_nxt   = SF_CNT_W'(1);
          acc_nxt   = '0;
          state_nxt = REF;
        end
      end
      REF: begin
        if (chip_valid_i) begin
          ref_we = 1'b1;
          if (cnt == last_idx) begin
            cnt_nxt   = '0;
            state_nxt = DATA;
          end else begin
            cnt_nxt = cnt + SF_CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (chip_valid_i) begin
          acc_nxt = acc + ACC_W'(prod);
          if (cnt == last_idx) begin
            cnt_nxt   = '0;
            state_nxt = OUT;
          end else begin
            cnt_nxt = cnt + SF_CNT_W'(1);
          end
        end
      end
      OUT: begin
        chip_ready_o = 1'b0;
        bit_valid_o  = 1'b1;
        bit_o        = ~acc[ACC_W-1];
        if (bit_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCSK_DEMOD_CORR_OUT_EN
  // Captured with the final product so it matches acc for the whole OUT phase.
  always_ff @(posedge clk) begin
    if (rst)                                  corr_o <= '0;
    else if (state == DATA && state_nxt == OUT) corr_o <= acc_nxt;
  end
`endif

endmodule
